// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN step sequencer and its bench.
package snn_pkg;
  localparam int SNN_IN_W      = 8;
  localparam int SNN_OUT_W     = 2;
  localparam int NUM_STEPS_DEF = 16;
  localparam int CNT_W_DEF     = 8;
  localparam int TIMEOUT_DEF   = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WAIT_IN = 3'd2,
    STEP    = 3'd3,
    ADV     = 3'd4,
    FINISH  = 3'd5
  } seq_state_e;
endpackage

// File: rtl/snn_step_sequencer_if.sv
// Input spike-frame handshake between the host/stimulus side and the sequencer.
interface snn_step_sequencer_if;
  import snn_pkg::*;
  logic                in_valid;
  logic                in_ready;
  logic [SNN_IN_W-1:0] in_spikes;

  modport master (output in_valid, output in_spikes, input in_ready);
  modport slave  (input in_valid, input in_spikes, output in_ready);
endinterface

// File: rtl/snn_spike_counter.sv
// Saturating spike counter with synchronous clear and increment enable.
module snn_spike_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/snn_step_sequencer.sv
// Time-step controller: one input frame per step, enable until the net reports
// ready, advance delay lines, accumulate output spikes, pick a winner at the end.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | network reset pulse, clear counters and results
// WAIT_IN | waiting for an input frame handshake
// STEP    | network enabled, waiting for net_data_ready or timeout
// ADV     | delay-line advance strobe, next step or finish
// FINISH  | done pulse, winner valid
module snn_step_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  snn_step_sequencer_if.slave  frame,
  output logic                 net_reset,
  output logic                 net_enable,
  output logic                 net_delay_clk,
  output logic [SNN_IN_W-1:0]  net_input_spikes,
  input  logic [SNN_OUT_W-1:0] net_out_spikes,
  input  logic                 net_data_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     count0,
  output logic [CNT_W-1:0]     count1,
  output logic                 class_out
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  seq_state_e state, next_state;
  logic [7:0]    step_cnt;
  logic [TW-1:0] to_cnt;
  logic          last_step, to_hit, step_done;

  assign last_step = (step_cnt == 8'(NUM_STEPS - 1));
  assign to_hit    = (to_cnt == TW'(TIMEOUT - 1));
  assign step_done = (state == STEP) && net_data_ready && !abort;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = WAIT_IN;
      WAIT_IN: if (frame.in_valid) next_state = STEP;
      STEP: begin
        if (net_data_ready) next_state = ADV;
        else if (to_hit)    next_state = FINISH;
      end
      ADV:     next_state = last_step ? FINISH : WAIT_IN;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // abort overrides every transition once an inference is running
    if (abort && (state != IDLE)) next_state = IDLE;
  end

  always_comb begin
    frame.in_ready = (state == WAIT_IN);
    net_reset      = (state == CLEAR);
    net_enable     = (state == STEP);
    net_delay_clk  = (state == ADV);
    busy           = (state != IDLE);
    done           = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt         <= '0;
      to_cnt           <= '0;
      timeout_err      <= 1'b0;
      class_out        <= 1'b0;
      net_input_spikes <= '0;
    end else begin
      case (state)
        CLEAR: begin
          step_cnt         <= '0;
          to_cnt           <= '0;
          timeout_err      <= 1'b0;
          class_out        <= 1'b0;
          net_input_spikes <= '0;
        end
        WAIT_IN: if (frame.in_valid && !abort) net_input_spikes <= frame.in_spikes;
        STEP:    to_cnt <= to_cnt + TW'(1);
        ADV: begin
          to_cnt <= '0;
          if (!last_step && !abort) step_cnt <= step_cnt + 8'd1;
        end
        default: ;
      endcase
      // results are captured on the edge into FINISH so they are valid with done
      if ((next_state == FINISH) && (state != FINISH)) begin
        class_out <= (count1 > count0);
        if (state == STEP) timeout_err <= 1'b1;
      end
    end
  end

  snn_spike_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .clr   (state == CLEAR),
    .inc   (step_done && net_out_spikes[0]),
    .count (count0)
  );

  snn_spike_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .clr   (state == CLEAR),
    .inc   (step_done && net_out_spikes[1]),
    .count (count1)
  );
endmodule
